// File: rtl/csi2tx_nlane_ldl.sv
// CSI-2 TX lane distribution: spreads each packet over 1..LANES PPI lanes with per-lane HS request masks.
// Optional macro CSI2TX_LDL_READY_ALL_EN: beat acceptance waits for txreadyhs on every requested lane.
module csi2tx_nlane_ldl #(
  parameter int LANES = 8,
  parameter int WC_W  = 17,
  parameter int HXW   = 8,
  parameter int LW    = $clog2(LANES + 1)
) (
  input  logic                 txbyteclkhs,
  input  logic                 txbyteclkhs_rst,
  input  logic                 tinit_start,
  input  logic                 forcetxstopmode,
  input  logic [LW-1:0]        active_lanes,
  input  logic                 enable_hs_transmission,
  input  logic                 csi_byte_fifo_empty,
  input  logic [8*LANES-1:0]   fifo_rd_data,
  input  logic                 short_packet,
  input  logic [WC_W-1:0]      pkt_byte_cnt,
  input  logic [HXW-1:0]       hs_exit_cycles,
  input  logic [LANES-1:0]     txreadyhs,
  input  logic                 stop_state_dl,
  output logic                 fifo_rd_en,
  output logic                 header_info,
  output logic [8*LANES-1:0]   txdatahs,
  output logic [LANES-1:0]     txrequesths,
  output logic                 hs_exit_active,
  output logic                 tx_done,
  output logic                 lane_cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HDR, S_DLY, S_REQ_HS, S_STOP, S_HS_EXIT
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     act_q, act_d;
  logic [WC_W-1:0]   rem_q, rem_d;
  logic [HXW-1:0]    cnt_q, cnt_d;
  logic [LANES-1:0]  req_q, req_d;

  logic              rdy;
  logic              accept;
  logic              last_beat;
  logic [WC_W-1:0]   n_cur;
  logic [WC_W-1:0]   rem_after;
  logic [WC_W-1:0]   rem_load;

  // Lowest min(rem, act) lanes are requested.
  function automatic logic [LANES-1:0] lane_mask(input logic [WC_W-1:0] rem,
                                                 input logic [LW-1:0]   act);
    logic [WC_W-1:0] n;
    lane_mask = '0;
    n = (rem < WC_W'(act)) ? rem : WC_W'(act);
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = (WC_W'(i) < n);
    end
  endfunction

`ifdef CSI2TX_LDL_READY_ALL_EN
  assign rdy = &(txreadyhs | ~req_q);
`else
  logic ready_unused;
  assign ready_unused = ^txreadyhs;
  assign rdy = txreadyhs[0];
`endif

  assign n_cur     = (rem_q < WC_W'(act_q)) ? rem_q : WC_W'(act_q);
  assign rem_after = rem_q - n_cur;
  assign last_beat = (rem_q == n_cur);
  assign accept    = (state_q == S_REQ_HS) && req_q[0] && rdy;
  assign rem_load  = short_packet ? WC_W'(4) :
                     ((pkt_byte_cnt == '0) ? WC_W'(1) : pkt_byte_cnt);

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    fifo_rd_en   = 1'b0;
    header_info  = 1'b0;
    lane_cfg_err = 1'b0;
    if (txbyteclkhs_rst || !tinit_start || forcetxstopmode) begin
      state_d = S_IDLE;
      req_d   = '0;
      rem_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_hs_transmission && !csi_byte_fifo_empty) begin
            if (active_lanes != '0 && active_lanes <= LW'(LANES)) begin
              state_d = S_RD_HDR;
              act_d   = active_lanes;
            end else begin
              lane_cfg_err = 1'b1;
            end
          end
        end
        S_RD_HDR: begin
          fifo_rd_en = 1'b1;
          state_d    = S_DLY;
        end
        S_DLY: begin
          header_info = 1'b1;
          rem_d       = rem_load;
          req_d       = lane_mask(rem_load, act_q);
          state_d     = S_REQ_HS;
        end
        S_REQ_HS: begin
          if (accept) begin
            rem_d = rem_after;
            if (last_beat) begin
              req_d   = '0;
              state_d = S_STOP;
            end else begin
              req_d      = lane_mask(rem_after, act_q);
              fifo_rd_en = 1'b1;
            end
          end
        end
        S_STOP: begin
          if (stop_state_dl) begin
            cnt_d   = hs_exit_cycles;
            state_d = S_HS_EXIT;
          end
        end
        S_HS_EXIT: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge txbyteclkhs) begin
    if (txbyteclkhs_rst) begin
      state_q <= S_IDLE;
      act_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign txdatahs[8*gi +: 8] = req_q[gi] ? fifo_rd_data[8*gi +: 8] : 8'h00;
  end

  assign txrequesths    = req_q;
  assign tx_done        = (state_q == S_STOP);
  assign hs_exit_active = (state_q == S_HS_EXIT);

endmodule

// File: tb/tb_csi2tx_nlane_ldl.sv
// Scoreboard bench for csi2tx_nlane_ldl: expected beats queued at stimulus time, checked by a monitor.
module tb_csi2tx_nlane_ldl;
  localparam int LANES = 8;
  localparam int WC_W  = 17;
  localparam int HXW   = 8;
  localparam int LW    = 4;

  logic              clk = 1'b0;
  logic              srst, tinit_start, force_stop, en, short_packet, stop_dl;
  logic [LW-1:0]     active_lanes;
  logic [WC_W-1:0]   pkt_cnt;
  logic [HXW-1:0]    hs_exit;
  logic [LANES-1:0]  txreadyhs;
  logic [63:0]       fifo_rd_data = '0;
  logic              fifo_empty;
  logic              fifo_rd_en, header_info, hs_exit_active, tx_done, lane_cfg_err;
  logic [63:0]       txdatahs;
  logic [LANES-1:0]  txrequesths;
  logic              tb_rdy;

  typedef struct {
    logic [7:0]  mask;
    logic [63:0] data;
  } beat_t;
  beat_t exp_q[$];

  logic [63:0] mem [0:63];
  int rd_ptr = 0;
  int wr_ptr = 0;
  logic fifo_flush = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;

  always #5 clk = ~clk;

  csi2tx_nlane_ldl #(.LANES(LANES), .WC_W(WC_W), .HXW(HXW), .LW(LW)) dut (
    .txbyteclkhs(clk), .txbyteclkhs_rst(srst), .tinit_start(tinit_start),
    .forcetxstopmode(force_stop), .active_lanes(active_lanes),
    .enable_hs_transmission(en), .csi_byte_fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .short_packet(short_packet), .pkt_byte_cnt(pkt_cnt),
    .hs_exit_cycles(hs_exit), .txreadyhs(txreadyhs), .stop_state_dl(stop_dl),
    .fifo_rd_en(fifo_rd_en), .header_info(header_info), .txdatahs(txdatahs),
    .txrequesths(txrequesths), .hs_exit_active(hs_exit_active), .tx_done(tx_done),
    .lane_cfg_err(lane_cfg_err)
  );

  // One-cycle-latency FIFO model
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && rd_ptr != wr_ptr) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

`ifdef CSI2TX_LDL_READY_ALL_EN
  assign tb_rdy = &(txreadyhs | ~txrequesths);
`else
  assign tb_rdy = txreadyhs[0];
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] masked(input int w, input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = mem[w][8*i +: 8];
    return r;
  endfunction

  // Monitor: count reads, pop and compare on every accepted beat
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) rd_cnt++;
      if (txrequesths[0] === 1'b1 && tb_rdy === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got mask %h, no beat expected", txrequesths);
        end else begin
          e = exp_q.pop_front();
          check("beat_mask", 64'(txrequesths), 64'(e.mask));
          check("beat_data", txdatahs, e.data);
          $display("[TB] beat mask=%h data=%h", txrequesths, txdatahs);
        end
      end
    end
  end

  // Loads nwords into the FIFO, queues nexp beats, starts the packet and checks start latency.
  // Returns at the falling edge of the first REQ_HS cycle.
  task automatic send_pkt(input logic [LW-1:0] act, input logic sp, input logic [WC_W-1:0] cnt,
                          input int nwords, input int nexp, input logic [31:0] masks);
    int base;
    beat_t b;
    @(posedge clk); #1;
    base = wr_ptr;
    for (int w = 0; w < nwords; w++)
      for (int i = 0; i < 8; i++) mem[base + w][8*i +: 8] = 8'((base + w) * 16 + i);
    for (int k = 0; k < nexp; k++) begin
      b.mask = masks[8*k +: 8];
      b.data = masked(base + k, masks[8*k +: 8]);
      exp_q.push_back(b);
    end
    wr_ptr = wr_ptr + nwords;
    active_lanes = act; short_packet = sp; pkt_cnt = cnt; en = 1'b1;
    @(negedge clk);
    check("start_c0_rd", 64'(fifo_rd_en), 64'd0);
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    check("start_c1_rd", 64'(fifo_rd_en), 64'd1);
    @(negedge clk);
    check("start_c2_hdr", 64'(header_info), 64'd1);
    @(negedge clk);
    check("start_c3_req", 64'(txrequesths), 64'(masks[7:0]));
  endtask

  task automatic wait_done(input int exp_k);
    int k = 0;
    while (tx_done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("tx_done_latency", 64'(k), 64'(exp_k));
    check("req_clear_at_done", 64'(txrequesths), 64'd0);
  endtask

  task automatic hs_exit_seq(input logic [HXW-1:0] hx);
    int c = 0;
    hs_exit = hx;
    stop_dl = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (hs_exit_active === 1'b1) c++;
      else if (c > 0) break;
    end
    stop_dl = 1'b0;
    check("hs_exit_len", 64'(c), 64'(hx) + 64'd1);
    check("done_after_exit", 64'(tx_done), 64'd0);
  endtask

  task automatic flush;
    @(posedge clk); #1;
    fifo_flush = 1'b1;
    @(posedge clk); #1;
    fifo_flush = 1'b0;
  endtask

  initial begin
    int r0;
    int b5;
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int b5;
    srst = 1'b1; tinit_start = 1'b1; force_stop = 1'b0; en = 1'b0; short_packet = 1'b0;
    stop_dl = 1'b0; active_lanes = 4'd4; pkt_cnt = '0; hs_exit = '0; txreadyhs = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 64'(txrequesths), 64'd0);
    check("rst_data", txdatahs, 64'd0);
    check("rst_flags", 64'({fifo_rd_en, header_info, tx_done, hs_exit_active, lane_cfg_err}), 64'd0);
    @(posedge clk); #1;
    srst = 1'b0;

    // long packet, 10 bytes over 4 lanes
    $display("[TB] txn: long 10B act=4");
    r0 = rd_cnt;
    send_pkt(4'd4, 1'b0, 17'd10, 3, 3, 32'h00_03_0F_0F);
    wait_done(3);
    check("t1_rd_count", 64'(rd_cnt - r0), 64'd3);
    hs_exit_seq(8'd0);

    // short packet, 8 lanes
    $display("[TB] txn: short act=8");
    r0 = rd_cnt;
    send_pkt(4'd8, 1'b1, 17'd99, 1, 1, 32'h0000_000F);
    wait_done(1);
    check("t2_rd_count", 64'(rd_cnt - r0), 64'd1);
    hs_exit_seq(8'd3);

    // illegal lane counts and tinit_start hold
    $display("[TB] txn: illegal active_lanes");
    @(posedge clk); #1;
    mem[wr_ptr] = 64'h1;
    wr_ptr = wr_ptr + 1;
    r0 = rd_cnt;
    active_lanes = 4'd0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("cfg_err_act0", 64'(lane_cfg_err), 64'd1);
    end
    @(posedge clk); #1;
    active_lanes = 4'd9;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("cfg_err_act9", 64'(lane_cfg_err), 64'd1);
    end
    check("cfg_err_no_rd", 64'(rd_cnt - r0), 64'd0);
    check("cfg_err_no_hdr", 64'(header_info), 64'd0);
    @(posedge clk); #1;
    active_lanes = 4'd4; tinit_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("tinit_hold", 64'({fifo_rd_en, lane_cfg_err}), 64'd0);
    end
    @(posedge clk); #1;
    tinit_start = 1'b1; en = 1'b0;
    flush();

    // abort on second beat of a 32-byte packet
    $display("[TB] txn: abort 32B act=8");
    send_pkt(4'd8, 1'b0, 17'd32, 4, 2, 32'h0000_FFFF);
    @(posedge clk); #1;
    force_stop = 1'b1;
    @(posedge clk); #1;
    force_stop = 1'b0;
    @(negedge clk);
    check("abort_req", 64'(txrequesths), 64'd0);
    check("abort_flags", 64'({tx_done, hs_exit_active, header_info}), 64'd0);
    flush();
    $display("[TB] txn: short act=2 after abort");
    send_pkt(4'd2, 1'b1, 17'd0, 2, 2, 32'h0000_0303);
    wait_done(2);
    hs_exit_seq(8'd1);

    // zero byte count behaves as one byte
    $display("[TB] txn: long 0B act=8");
    send_pkt(4'd8, 1'b0, 17'd0, 1, 1, 32'h0000_0001);
    wait_done(1);
    hs_exit_seq(8'd0);

    // stall on ready low, act=3, 7 bytes
    $display("[TB] txn: stall 7B act=3");
    send_pkt(4'd3, 1'b0, 17'd7, 3, 3, 32'h00_01_07_07);
    @(posedge clk); #1;
    txreadyhs = 8'h00;
    r0 = rd_cnt;
    @(negedge clk);
    check("stall_req_c4", 64'(txrequesths), 64'h07);
    @(negedge clk);
    check("stall_req_c5", 64'(txrequesths), 64'h07);
    check("stall_no_rd", 64'(rd_cnt - r0), 64'd0);
    @(posedge clk); #1;
    txreadyhs = 8'hFF;
    wait_done(3);
    hs_exit_seq(8'd0);

    // partial ready 0x7F
    $display("[TB] txn: partial ready act=8");
    txreadyhs = 8'h7F;
    b5 = wr_ptr;
    send_pkt(4'd8, 1'b0, 17'd8, 1, 1, 32'h0000_00FF);
`ifdef CSI2TX_LDL_READY_ALL_EN
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rdy_all_hold_req", 64'(txrequesths), 64'hFF);
      check("rdy_all_hold_data", txdatahs, masked(b5, 8'hFF));
    end
    @(posedge clk); #1;
    txreadyhs = 8'hFF;
    wait_done(2);
`else
    check("rdy0_data", txdatahs, masked(b5, 8'hFF));
    wait_done(1);
    txreadyhs = 8'hFF;
`endif
    hs_exit_seq(8'd2);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
